// File: rtl/oam_dma.sv
// oam_dma: sprite-memory DMA engine on the CPU bus.
// A CPU write of a page number to TRIGGER_ADDR halts the CPU and copies the
// 256 bytes of that page to DEST_ADDR, one read cycle plus one write cycle
// per byte. While idle the CPU bus is passed straight through to memory.
// Optional feature macro: OAM_DMA_PARITY_ALIGN_EN. When defined, the halt is
// stretched so that every READ cycle starts with phase == 0.
module oam_dma #(
    parameter int                    WIDTH        = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR    = 16'h2004
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [WIDTH-1:0]      cpu_dout,
    input  logic [WIDTH-1:0]      bus_din,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_we,
    output logic [WIDTH-1:0]      bus_dout,
    output logic                  cpu_rdy,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       page_q;
    logic [7:0]       page_d;
    logic [7:0]       idx_q;
    logic [7:0]       idx_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             phase_q;
    logic             phase_d;
    logic             cpu_rdy_q;
    logic             cpu_rdy_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             trigger_s;
    logic             align_exit_s;

    // A DMA request is a CPU write to the trigger address; only honoured in IDLE.
    assign trigger_s = cpu_we && (cpu_addr == TRIGGER_ADDR);

`ifdef OAM_DMA_PARITY_ALIGN_EN
    // Leave ALIGN only when the next cycle will have phase == 0.
    assign align_exit_s = phase_q;
`else
    // Single ALIGN cycle; phase is kept running but does not gate anything.
    assign align_exit_s = 1'b1;
`endif

    // Next-state, datapath updates and bus multiplexing for the transfer FSM.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        phase_d  = ~phase_q;
        done_d   = 1'b0;
        bus_addr = cpu_addr;
        bus_we   = cpu_we;
        bus_dout = cpu_dout;
        case (state_q)
            ST_IDLE: begin
                // The trigger write itself still reaches memory via pass-through.
                if (trigger_s) begin
                    page_d  = cpu_dout[7:0];
                    idx_d   = 8'h00;
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                bus_we   = 1'b0;
                bus_dout = {WIDTH{1'b0}};
                if (align_exit_s) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_READ: begin
                // Source address never leaves the page: idx is only 8 bits.
                bus_addr = ADDR_WIDTH'({page_q, idx_q});
                bus_we   = 1'b0;
                bus_dout = {WIDTH{1'b0}};
                data_d   = bus_din;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                bus_addr = DEST_ADDR;
                bus_we   = 1'b1;
                bus_dout = data_q;
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they line up
        // with the state register.
        cpu_rdy_d = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            data_q    <= {WIDTH{1'b0}};
            phase_q   <= 1'b0;
            cpu_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            phase_q   <= phase_d;
            cpu_rdy_q <= cpu_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cpu_rdy = cpu_rdy_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: self-checking bench for oam_dma. A 64 KiB byte memory sits on
// the bus; every DMA is checked against a snapshot of the source page and the
// expected halt length derived from the clock phase at the trigger edge.
module tb_oam_dma;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DEST = 16'h2004;

    logic        clk;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic [7:0]  bus_din;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_dout;
    logic        cpu_rdy;
    logic        busy;
    logic        done;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  snap [256];
    int          a_exp;
    int          edge_cnt = 0;
    int          rdy_low  = 0;
    int          done_cnt = 0;
    logic [15:0] la [$];
    logic        lw [$];
    logic [7:0]  ld [$];
    logic [15:0] lc [$];

    oam_dma dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_addr (cpu_addr),
        .cpu_we   (cpu_we),
        .cpu_dout (cpu_dout),
        .bus_din  (bus_din),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_dout (bus_dout),
        .cpu_rdy  (cpu_rdy),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_din = mem[bus_addr];

    // Synchronous memory write and a count of edges since reset (clock phase).
    always @(posedge clk) begin
        if (bus_we === 1'b1) mem[bus_addr] <= bus_dout;
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // Mid-cycle observation of bus traffic during busy cycles and status pulses.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            la.push_back(bus_addr);
            lw.push_back(bus_we);
            ld.push_back(bus_dout);
            lc.push_back(cpu_addr);
        end
        if (cpu_rdy === 1'b0) rdy_low++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        do a = 16'($urandom); while (a == TRIG);
        return a;
    endfunction

    function automatic logic [7:0] rand_page();
        logic [7:0] p;
        do p = 8'($urandom); while (p == 8'h20);
        return p;
    endfunction

    // Issue a trigger write, then snapshot the source and predict ALIGN count.
    task automatic trigger(input logic [7:0] pg);
        la.delete(); lw.delete(); ld.delete(); lc.delete();
        rdy_low  = 0;
        done_cnt = 0;
        cpu_addr = TRIG;
        cpu_we   = 1'b1;
        cpu_dout = pg;
        cyc();
        cpu_addr = rand_addr();
        cpu_we   = 1'($urandom);
        cpu_dout = 8'($urandom);
        for (int i = 0; i < 256; i++) snap[i] = mem[{pg, 8'(i)}];
`ifdef OAM_DMA_PARITY_ALIGN_EN
        a_exp = (edge_cnt[0] == 1'b1) ? 1 : 2;
`else
        a_exp = 1;
`endif
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (cpu_rdy === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        cpu_we = 1'b0;
    endtask

    // Count deviations of the logged busy window from the ideal transfer.
    function automatic int copy_errs(input logic [7:0] pg, input int nb);
        int e = 0;
        for (int i = 0; i < a_exp; i++)
            if (lw[i] !== 1'b0 || ld[i] !== 8'h00 || la[i] !== lc[i]) e++;
        for (int n = 0; n < nb; n++) begin
            if (lw[a_exp + 2*n] !== 1'b0 || la[a_exp + 2*n] !== {pg, 8'(n)}) e++;
            if (lw[a_exp + 2*n + 1] !== 1'b1 || la[a_exp + 2*n + 1] !== DEST ||
                ld[a_exp + 2*n + 1] !== snap[n]) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        reset_n  = 1'b0;
        cpu_addr = TRIG;
        cpu_we   = 1'b1;
        cpu_dout = 8'($urandom);
        cyc();
        cyc();
        checks++;
        if (cpu_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: rdy/busy/done=%b%b%b required 100", cpu_rdy, busy, done);
        end
        checks++;
        if (bus_addr !== cpu_addr || bus_we !== cpu_we || bus_dout !== cpu_dout) begin
            fails++;
            $display("FAIL reset_bus: %h/%b/%h required %h/%b/%h", bus_addr, bus_we, bus_dout, cpu_addr, cpu_we, cpu_dout);
        end
        reset_n = 1'b1;
        cpu_we  = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || cpu_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_beats_trigger: busy=%b rdy=%b required 0/1", busy, cpu_rdy);
        end
    endtask

    task automatic test_pass_through();
        cpu_addr = 16'h0010;
        cpu_we   = 1'b1;
        cpu_dout = 8'h5A;
        #1;
        checks++;
        if (bus_addr !== 16'h0010 || bus_we !== 1'b1 || bus_dout !== 8'h5A) begin
            fails++;
            $display("FAIL pass_fixed: %h/%b/%h required 0010/1/5a", bus_addr, bus_we, bus_dout);
        end
        cyc();
        cpu_we = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem[16'h0010] !== 8'h5A) begin
            fails++;
            $display("FAIL pass_fixed_after: busy=%b mem=%h required 0/5a", busy, mem[16'h0010]);
        end
        for (int k = 0; k < 6; k++) begin
            cpu_addr = rand_addr();
            cpu_we   = 1'($urandom);
            cpu_dout = 8'($urandom);
            #1;
            checks++;
            if (bus_addr !== cpu_addr || bus_we !== cpu_we || bus_dout !== cpu_dout) begin
                fails++;
                $display("FAIL pass_rand: %h/%b/%h required %h/%b/%h", bus_addr, bus_we, bus_dout, cpu_addr, cpu_we, cpu_dout);
            end
            cyc();
            checks++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL pass_rand_idle: busy=%b required 0", busy);
            end
        end
        cpu_addr = TRIG;
        cpu_we   = 1'b0;
        cyc();
        cyc();
        checks++;
        if (busy !== 1'b0 || cpu_rdy !== 1'b1) begin
            fails++;
            $display("FAIL trigger_read_no_dma: busy=%b rdy=%b required 0/1", busy, cpu_rdy);
        end
    endtask

    task automatic test_basic_copy();
        bit to;
        int e;
        for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n);
        trigger(8'h02);
        checks++;
        if (cpu_rdy !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_halt_start: rdy=%b busy=%b required 0/1", cpu_rdy, busy);
        end
        wait_done(to);
        checks++;
        if (to) begin fails++; $display("FAIL basic_timeout: no completion, required within 1000 cycles"); end
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL basic_done_with_rdy: done=%b required 1", done); end
        checks++;
        if (rdy_low != 512 + a_exp || la.size() != 512 + a_exp) begin
            fails++;
            $display("FAIL basic_length: halt=%0d busy_cycles=%0d required %0d", rdy_low, la.size(), 512 + a_exp);
        end
        e = copy_errs(8'h02, 256);
        checks++;
        if (e !== 0) begin fails++; $display("FAIL basic_copy: %0d bad cycles required 0", e); end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1 || mem[DEST] !== 8'hFF) begin
            fails++;
            $display("FAIL basic_after: done=%b busy=%b pulses=%0d dest=%h required 0/0/1/ff", done, busy, done_cnt, mem[DEST]);
        end
    endtask

    task automatic test_halt_length();
        bit to;
        int exp_halt;
        logic [7:0] pg;
        for (int p = 0; p < 2; p++) begin
            pg = rand_page();
            for (int n = 0; n < 256; n++) mem[{pg, 8'(n)}] = 8'($urandom);
            // Phase after the trigger edge equals the parity of edge_cnt + 1.
            if (((edge_cnt + 1) % 2) != p) cyc();
`ifdef OAM_DMA_PARITY_ALIGN_EN
            exp_halt = (p == 1) ? 513 : 514;
`else
            exp_halt = 513;
`endif
            trigger(pg);
            wait_done(to);
            checks++;
            if (to || rdy_low != exp_halt) begin
                fails++;
                $display("FAIL halt_phase%0d: halt=%0d timeout=%b required %0d", p, rdy_low, to, exp_halt);
            end
            checks++;
            if (copy_errs(pg, 256) !== 0) begin
                fails++;
                $display("FAIL halt_phase%0d_copy: page %h copy wrong, required exact", p, pg);
            end
            cyc();
        end
    endtask

    task automatic test_top_page();
        bit to;
        int zero_reads = 0;
        for (int n = 0; n < 256; n++) mem[16'hFF00 + n] = ~8'(n);
        trigger(8'hFF);
        wait_done(to);
        for (int n = 0; n < 256; n++) if (la[a_exp + 2*n] === 16'h0000) zero_reads++;
        checks++;
        if (to || la[a_exp + 510] !== 16'hFFFF || zero_reads != 0) begin
            fails++;
            $display("FAIL top_last_read: addr=%h wraps=%0d required ffff/0", la[a_exp + 510], zero_reads);
        end
        checks++;
        if (ld[a_exp + 511] !== 8'h00 || mem[DEST] !== 8'h00) begin
            fails++;
            $display("FAIL top_last_write: data=%h required 00", ld[a_exp + 511]);
        end
        checks++;
        if (copy_errs(8'hFF, 256) !== 0) begin fails++; $display("FAIL top_copy: copy wrong, required exact"); end
        cyc();
    endtask

    task automatic test_random_pages();
        bit to;
        logic [7:0] pg;
        for (int k = 0; k < 3; k++) begin
            pg = rand_page();
            for (int n = 0; n < 256; n++) mem[{pg, 8'(n)}] = 8'($urandom);
            trigger(pg);
            wait_done(to);
            checks++;
            if (to || copy_errs(pg, 256) !== 0 || la.size() != 512 + a_exp) begin
                fails++;
                $display("FAIL random_page_%h: busy_cycles=%0d required %0d exact copy", pg, la.size(), 512 + a_exp);
            end
            cyc();
            checks++;
            if (done_cnt != 1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL random_page_done: pulses=%0d busy=%b required 1/0", done_cnt, busy);
            end
        end
    endtask

    task automatic test_trigger_while_busy();
        bit to;
        for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'($urandom);
        trigger(8'h02);
        cpu_we = 1'b0;
        repeat (99) cyc();
        cpu_addr = TRIG;
        cpu_we   = 1'b1;
        cpu_dout = 8'h05;
        cyc();
        cpu_addr = rand_addr();
        cpu_we   = 1'b0;
        wait_done(to);
        checks++;
        if (to || rdy_low != 512 + a_exp || done_cnt != 1) begin
            fails++;
            $display("FAIL busy_trigger_length: halt=%0d pulses=%0d required %0d/1", rdy_low, done_cnt, 512 + a_exp);
        end
        checks++;
        if (copy_errs(8'h02, 256) !== 0 || mem[TRIG] !== 8'h02) begin
            fails++;
            $display("FAIL busy_trigger_copy: trig_mem=%h required page 02 copy and 02", mem[TRIG]);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_trigger_restart: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [7:0] pg1;
        logic [7:0] pg2;
        pg1 = rand_page();
        pg2 = rand_page();
        for (int n = 0; n < 256; n++) mem[{pg1, 8'(n)}] = 8'($urandom);
        trigger(pg1);
        wait_done(to);
        checks++;
        if (to || done !== 1'b1 || copy_errs(pg1, 256) !== 0) begin
            fails++;
            $display("FAIL b2b_first: done=%b timeout=%b required 1/0 exact copy", done, to);
        end
        for (int n = 0; n < 256; n++) mem[{pg2, 8'(n)}] = 8'($urandom);
        trigger(pg2);
        checks++;
        if (cpu_rdy !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accepted: rdy=%b busy=%b required 0/1", cpu_rdy, busy);
        end
        wait_done(to);
        checks++;
        if (to || done !== 1'b1 || copy_errs(pg2, 256) !== 0 || rdy_low != 512 + a_exp) begin
            fails++;
            $display("FAIL b2b_second: done=%b halt=%0d required 1/%0d exact copy", done, rdy_low, 512 + a_exp);
        end
        cyc();
    endtask

    task automatic test_reset_mid_transfer();
        bit to;
        int nwr = 0;
        int bad = 0;
        logic [7:0] pg;
        pg = rand_page();
        for (int n = 0; n < 256; n++) mem[{pg, 8'(n)}] = 8'($urandom);
        trigger(pg);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (la.size() >= a_exp + 81) begin to = 1'b0; break; end
            cyc();
        end
        checks++;
        if (to) begin fails++; $display("FAIL midreset_reach: busy_cycles=%0d required %0d", la.size(), a_exp + 81); end
        reset_n = 1'b0;
        cpu_we  = 1'b0;
        cyc();
        reset_n = 1'b1;
        checks++;
        if (cpu_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_status: rdy/busy/done=%b%b%b required 100", cpu_rdy, busy, done);
        end
        cpu_addr = rand_addr();
        cpu_we   = 1'b1;
        cpu_dout = 8'($urandom);
        #1;
        checks++;
        if (bus_addr !== cpu_addr || bus_we !== 1'b1 || bus_dout !== cpu_dout) begin
            fails++;
            $display("FAIL midreset_bus: %h/%b/%h required %h/1/%h", bus_addr, bus_we, bus_dout, cpu_addr, cpu_dout);
        end
        cpu_addr = rand_addr();
        cpu_we   = 1'b0;
        for (int i = 0; i < lw.size(); i++) begin
            if (lw[i] === 1'b1) begin
                if (ld[i] !== snap[nwr]) bad++;
                nwr++;
            end
        end
        checks++;
        if (nwr != 40 || bad != 0 || mem[DEST] !== snap[39]) begin
            fails++;
            $display("FAIL midreset_partial: writes=%0d bad=%0d dest=%h required 40/0/%h", nwr, bad, mem[DEST], snap[39]);
        end
        repeat (5) cyc();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: pulses=%0d busy=%b required 0/0", done_cnt, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset_n  = 1'b0;
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
        cpu_dout = 8'h00;
        test_reset();
        test_pass_through();
        test_basic_copy();
        test_halt_length();
        test_top_page();
        test_random_pages();
        test_trigger_while_busy();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
